// File: rtl/noc_ingress_scheduler.sv
// noc_ingress_scheduler
//  Buffers the five group-router ingress streams (NI/GPU + four spine ports)
//  in per-requester FIFOs and arbitrates them onto one router ingress channel
//  with a credit-gated round-robin arbiter that bounds burst length.
// Ports
//  ACLK, ARESETn       clock, asynchronous active-low reset
//  arb_enable          1 = grants allowed, 0 = hold (FIFOs still fill)
//  in_data/in_dest     packed per-requester flits, requester i at slice i
//  in_valid            per-requester flit strobe (no backpressure)
//  out_data/out_dest   granted flit, registered
//  out_src/out_valid   granted requester index, one-cycle strobe
//  credit_return       downstream freed one slot
//  credits_avail       current credit count
//  grant_onehot        requester granted this cycle (combinational)
//  fifo_full/empty     per-requester FIFO status
//  overflow            sticky per-requester drop flag, overflow_clr clears
//  credit_err          sticky: credit returned at full count
module noc_ingress_scheduler #(
    parameter int unsigned N          = 5,
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned DEST_W     = 6,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CREDITS    = 4,
    parameter int unsigned MAX_BURST  = 2
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic                           arb_enable,
    input  logic [N*DWIDTH-1:0]            in_data,
    input  logic [N*DEST_W-1:0]            in_dest,
    input  logic [N-1:0]                   in_valid,
    output logic [DWIDTH-1:0]              out_data,
    output logic [DEST_W-1:0]              out_dest,
    output logic [2:0]                     out_src,
    output logic                           out_valid,
    input  logic                           credit_return,
    output logic [$clog2(CREDITS+1)-1:0]   credits_avail,
    output logic [N-1:0]                   grant_onehot,
    output logic [N-1:0]                   fifo_full,
    output logic [N-1:0]                   fifo_empty,
    output logic [N-1:0]                   overflow,
    input  logic                           overflow_clr,
    output logic                           credit_err
);

    localparam int unsigned ENT_W = DEST_W + DWIDTH;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned CRD_W = $clog2(CREDITS + 1);
    localparam int unsigned BST_W = $clog2(MAX_BURST + 1);

    // FIFO storage and pointers
    logic [ENT_W-1:0] mem_q    [N][FIFO_DEPTH];
    logic [ENT_W-1:0] mem_d    [N][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [N];
    logic [PTR_W-1:0] wr_ptr_d [N];
    logic [PTR_W-1:0] rd_ptr_q [N];
    logic [PTR_W-1:0] rd_ptr_d [N];
    logic [CNT_W-1:0] cnt_q    [N];
    logic [CNT_W-1:0] cnt_d    [N];

    // Arbiter / output state
    logic [IDX_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]  last_src_q,  last_src_d;
    logic [BST_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [CRD_W-1:0]  credits_q,   credits_d;
    logic              credit_err_q, credit_err_d;
    logic [N-1:0]      overflow_q,  overflow_d;
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] out_data_q,  out_data_d;
    logic [DEST_W-1:0] out_dest_q,  out_dest_d;
    logic [2:0]        out_src_q,   out_src_d;

    logic [N-1:0]      full_c, empty_c, elig_c, grant_c, push_c, drop_c;
    logic              gnt_valid_c;
    logic [IDX_W-1:0]  gnt_src_c;
    logic [ENT_W-1:0]  head_c;

    // FIFO status decode
    always_comb begin
        full_c  = '0;
        empty_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            full_c[i]  = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
            empty_c[i] = (cnt_q[i] == '0);
        end
    end

    assign elig_c = ~empty_c & {N{arb_enable && (credits_q != '0)}};

    // Round-robin search from rr_ptr; last_src keeps priority while its burst lasts.
    // rr_ptr always sits just past last_src, so an exhausted last_src is searched last.
    always_comb begin
        logic [IDX_W-1:0] idx;
        gnt_valid_c = 1'b0;
        gnt_src_c   = '0;
        idx         = '0;
        if (elig_c[last_src_q] && (burst_cnt_q < BST_W'(MAX_BURST))) begin
            gnt_valid_c = 1'b1;
            gnt_src_c   = last_src_q;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                idx = IDX_W'((int'(rr_ptr_q) + k) % int'(N));
                if (!gnt_valid_c && elig_c[idx]) begin
                    gnt_valid_c = 1'b1;
                    gnt_src_c   = idx;
                end
            end
        end
    end

    always_comb begin
        grant_c = '0;
        if (gnt_valid_c) begin
            grant_c[gnt_src_c] = 1'b1;
        end
    end

    // A full FIFO still accepts a write when it is popped in the same cycle
    assign push_c = in_valid & (~full_c | grant_c);
    assign drop_c = in_valid & full_c & ~grant_c;
    assign head_c = mem_q[gnt_src_c][rd_ptr_q[gnt_src_c]];

    // FIFO next state and sticky overflow (set wins over clear)
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        overflow_d = (overflow_clr ? '0 : overflow_q) | drop_c;
        for (int i = 0; i < int'(N); i++) begin
            if (push_c[i]) begin
                mem_d[i][wr_ptr_q[i]] = {in_dest[i*DEST_W +: DEST_W], in_data[i*DWIDTH +: DWIDTH]};
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
            end
            if (grant_c[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            case ({push_c[i], grant_c[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Output register, arbiter state and credit accounting
    always_comb begin
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_dest_d   = out_dest_q;
        out_src_d    = out_src_q;
        rr_ptr_d     = rr_ptr_q;
        last_src_d   = last_src_q;
        burst_cnt_d  = '0;
        credits_d    = credits_q;
        credit_err_d = credit_err_q | (credit_return && (credits_q == CRD_W'(CREDITS)));

        if (gnt_valid_c) begin
            out_valid_d = 1'b1;
            out_data_d  = head_c[DWIDTH-1:0];
            out_dest_d  = head_c[ENT_W-1:DWIDTH];
            out_src_d   = 3'(gnt_src_c);
            rr_ptr_d    = (gnt_src_c == IDX_W'(N - 1)) ? '0 : gnt_src_c + IDX_W'(1);
            last_src_d  = gnt_src_c;
            if (gnt_src_c == last_src_q) begin
                burst_cnt_d = (burst_cnt_q == BST_W'(MAX_BURST)) ? burst_cnt_q
                                                                 : burst_cnt_q + BST_W'(1);
            end else begin
                burst_cnt_d = BST_W'(1);
            end
        end

        case ({gnt_valid_c, credit_return})
            2'b10: credits_d = credits_q - CRD_W'(1);
            2'b01: if (credits_q != CRD_W'(CREDITS)) credits_d = credits_q + CRD_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < int'(N); i++) begin
                for (int j = 0; j < int'(FIFO_DEPTH); j++) begin
                    mem_q[i][j] <= '0;
                end
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_ptr_q     <= '0;
            last_src_q   <= '0;
            burst_cnt_q  <= '0;
            credits_q    <= CRD_W'(CREDITS);
            credit_err_q <= 1'b0;
            overflow_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_dest_q   <= '0;
            out_src_q    <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            last_src_q   <= last_src_d;
            burst_cnt_q  <= burst_cnt_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
            overflow_q   <= overflow_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_dest_q   <= out_dest_d;
            out_src_q    <= out_src_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_dest      = out_dest_q;
    assign out_src       = out_src_q;
    assign credits_avail = credits_q;
    assign credit_err    = credit_err_q;
    assign overflow      = overflow_q;
    assign grant_onehot  = grant_c;
    assign fifo_full     = full_c;
    assign fifo_empty    = empty_c;

endmodule

// File: tb/tb_noc_ingress_scheduler.sv
// Testbench for noc_ingress_scheduler: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_noc_ingress_scheduler;

    localparam int N     = 5;
    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 4;
    localparam int CRED  = 4;
    localparam int MAXB  = 2;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic              arb_enable;
    logic [N*DW-1:0]   in_data;
    logic [N*AW-1:0]   in_dest;
    logic [N-1:0]      in_valid;
    logic [DW-1:0]     out_data;
    logic [AW-1:0]     out_dest;
    logic [2:0]        out_src;
    logic              out_valid;
    logic              credit_return;
    logic [2:0]        credits_avail;
    logic [N-1:0]      grant_onehot;
    logic [N-1:0]      fifo_full;
    logic [N-1:0]      fifo_empty;
    logic [N-1:0]      overflow;
    logic              overflow_clr;
    logic              credit_err;

    always #5 ACLK = ~ACLK;

    noc_ingress_scheduler #(
        .N(N), .DWIDTH(DW), .DEST_W(AW), .FIFO_DEPTH(DEPTH), .CREDITS(CRED), .MAX_BURST(MAXB)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .arb_enable(arb_enable),
        .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid),
        .out_data(out_data), .out_dest(out_dest), .out_src(out_src), .out_valid(out_valid),
        .credit_return(credit_return), .credits_avail(credits_avail),
        .grant_onehot(grant_onehot), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow(overflow), .overflow_clr(overflow_clr), .credit_err(credit_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one queue per requester, arbitration from the rules
    logic [AW+DW-1:0] mq [N][$];
    int               m_cred, m_rr, m_last, m_burst;
    logic             m_err;
    logic [N-1:0]     m_ovf;
    logic             m_ov;
    logic [DW-1:0]    m_od;
    logic [AW-1:0]    m_oa;
    int               m_os;

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_cred = CRED; m_rr = 0; m_last = 0; m_burst = 0;
        m_err = 1'b0; m_ovf = '0; m_ov = 1'b0; m_od = '0; m_oa = '0; m_os = 0;
    endtask

    function automatic int model_pick();
        if (!arb_enable || m_cred == 0) return -1;
        if (mq[m_last].size() != 0 && m_burst < MAXB) return m_last;
        for (int k = 0; k < N; k++) begin
            if (mq[(m_rr + k) % N].size() != 0) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        logic [N-1:0] e_empty, e_full;
        for (int i = 0; i < N; i++) begin
            e_empty[i] = (mq[i].size() == 0);
            e_full[i]  = (mq[i].size() == DEPTH);
        end
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data", 32'(out_data), 32'(m_od));
        check("out_dest", 32'(out_dest), 32'(m_oa));
        check("out_src", 32'(out_src), 32'(m_os));
        check("credits", 32'(credits_avail), 32'(m_cred));
        check("credit_err", 32'(credit_err), 32'(m_err));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("fifo_empty", 32'(fifo_empty), 32'(e_empty));
        check("fifo_full", 32'(fifo_full), 32'(e_full));
    endtask

    // One clock cycle with inputs already applied: check grant, advance model, check outputs
    task automatic cycle();
        int           g, c0;
        logic [N-1:0] eg;
        logic [N-1:0] one;
        one = 1;
        #1;
        g  = model_pick();
        eg = (g >= 0) ? (one << g) : '0;
        check("grant", 32'(grant_onehot), 32'(eg));
        c0 = m_cred;
        if (g >= 0) begin
            {m_oa, m_od} = mq[g].pop_front();
            m_ov    = 1'b1;
            m_os    = g;
            m_burst = (g == m_last) ? ((m_burst < MAXB) ? m_burst + 1 : MAXB) : 1;
            m_last  = g;
            m_rr    = (g + 1) % N;
        end else begin
            m_ov    = 1'b0;
            m_burst = 0;
        end
        if (overflow_clr) m_ovf = '0;
        for (int i = 0; i < N; i++) begin
            if (in_valid[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back({in_dest[i*AW +: AW], in_data[i*DW +: DW]});
                else m_ovf[i] = 1'b1;
            end
        end
        if (credit_return && c0 == CRED) m_err = 1'b1;
        if (g >= 0 && !credit_return) m_cred--;
        else if (g < 0 && credit_return && c0 < CRED) m_cred++;
        @(posedge ACLK);
        #1;
        check_outputs();
    endtask

    task automatic set_in(input logic [N-1:0] v, input logic en, input logic ret, input logic clr);
        in_valid      = v;
        arb_enable    = en;
        credit_return = ret;
        overflow_clr  = clr;
        for (int i = 0; i < N; i++) begin
            in_data[i*DW +: DW] = DW'($urandom);
            in_dest[i*AW +: AW] = AW'($urandom);
        end
    endtask

    task automatic do_reset();
        set_in('0, 1'b0, 1'b0, 1'b0);
        ARESETn = 1'b0;
        model_reset();
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        check_outputs();
    endtask

    int             exp_order [15] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 1, 2, 3, 4};
    int             pulses;
    logic [DW-1:0]  got_q [$];

    initial begin
        ARESETn = 1'b0;
        set_in('0, 1'b0, 1'b0, 1'b0);
        do_reset();
        check("rst_credits", 32'(credits_avail), 32'd4);
        check("rst_empty", 32'(fifo_empty), 32'h1F);

        // Single flit latency
        set_in(5'b00100, 1'b1, 1'b0, 1'b0);
        in_data[2*DW +: DW] = 16'hA5A5;
        in_dest[2*AW +: AW] = 6'h12;
        cycle();
        check("t2_lat1", 32'(out_valid), 32'd0);
        set_in('0, 1'b1, 1'b0, 1'b0);
        cycle();
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_src", 32'(out_src), 32'd2);
        check("t2_data", 32'(out_data), 32'hA5A5);
        check("t2_dest", 32'(out_dest), 32'h12);
        check("t2_credits", 32'(credits_avail), 32'd3);
        cycle();
        check("t2_pulse", 32'(out_valid), 32'd0);

        // Round robin with bursts
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(5'h1F, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        for (int k = 0; k < 15; k++) begin
            set_in('0, 1'b1, 1'b1, 1'b0);
            cycle();
            check("t3_valid", 32'(out_valid), 32'd1);
            check("t3_order", 32'(out_src), 32'(exp_order[k]));
        end
        check("t3_err", 32'(credit_err), 32'd1);

        // Credit stall
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in((k < 2) ? 5'b01001 : 5'b00001, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            set_in('0, 1'b1, 1'b0, 1'b0);
            cycle();
            if (out_valid) pulses++;
        end
        check("t4_pulses", 32'(pulses), 32'd4);
        check("t4_zero", 32'(credits_avail), 32'd0);
        pulses = 0;
        set_in('0, 1'b1, 1'b1, 1'b0);
        cycle();
        for (int k = 0; k < 5; k++) begin
            set_in('0, 1'b1, 1'b0, 1'b0);
            cycle();
            if (out_valid) pulses++;
        end
        check("t4_one_more", 32'(pulses), 32'd1);

        // Overflow while held, then in-order drain
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_in(5'b00010, 1'b0, 1'b0, 1'b0);
            in_data[DW +: DW] = 16'(16'h1000 + k);
            cycle();
        end
        check("t5_full", 32'(fifo_full[1]), 32'd1);
        check("t5_ovf", 32'(overflow[1]), 32'd1);
        got_q.delete();
        for (int k = 0; k < 8; k++) begin
            set_in('0, 1'b1, 1'b0, 1'b0);
            cycle();
            if (out_valid) got_q.push_back(out_data);
        end
        check("t5_count", 32'(got_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            check("t5_order", 32'(got_q[k]), 32'(16'h1000 + k));
        end

        // Simultaneous events
        do_reset();
        set_in(5'b00001, 1'b1, 1'b0, 1'b0);
        cycle();
        set_in(5'b00001, 1'b1, 1'b0, 1'b0);
        cycle();
        check("t6_cred3", 32'(credits_avail), 32'd3);
        set_in('0, 1'b1, 1'b1, 1'b0);
        cycle();
        check("t6_gnt_ret_v", 32'(out_valid), 32'd1);
        check("t6_gnt_ret", 32'(credits_avail), 32'd3);
        for (int k = 0; k < 5; k++) begin
            set_in(5'b10000, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        set_in(5'b10000, 1'b0, 1'b0, 1'b1);
        cycle();
        check("t6_set_wins", 32'(overflow[4]), 32'd1);
        set_in('0, 1'b0, 1'b1, 1'b1);
        cycle();
        check("t6_clr", 32'(overflow[4]), 32'd0);
        check("t6_cred4", 32'(credits_avail), 32'd4);
        check("t6_no_err", 32'(credit_err), 32'd0);
        set_in('0, 1'b0, 1'b1, 1'b0);
        cycle();
        check("t6_err", 32'(credit_err), 32'd1);
        check("t6_sat", 32'(credits_avail), 32'd4);

        // Randomized traffic; credits returned only while some are outstanding
        do_reset();
        for (int k = 0; k < 600; k++) begin
            set_in(N'($urandom) & N'($urandom),
                   ($urandom_range(0, 7) != 0),
                   (m_cred < CRED) && ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 15) == 0));
            cycle();
        end

        // Asynchronous reset mid-traffic
        set_in(5'h1F, 1'b1, 1'b0, 1'b0);
        ARESETn = 1'b0;
        #2;
        check("t1_valid", 32'(out_valid), 32'd0);
        check("t1_credits", 32'(credits_avail), 32'd4);
        check("t1_empty", 32'(fifo_empty), 32'h1F);
        check("t1_ovf", 32'(overflow), 32'd0);
        model_reset();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        set_in('0, 1'b0, 1'b0, 1'b0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
